// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for the sequential binary-to-BCD converter.
// The requester drives start/bin; the converter answers with busy/done/bcd.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, each BCD digit passed
// through an add3 cell before the shift. The result is published with a one-cycle done pulse.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  bin2bcd_seq_if.slave      bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   cnt;
  logic               busy_q;
  logic               done_q;

  function automatic logic [3:0] add3(input logic [3:0] num);
    return (num >= 4'd5) ? num + 4'd3 : num;
  endfunction

  always_comb begin
    adj       = '0;
    state_nxt = state;
    for (int d = 0; d < DIGITS; d++) begin
      adj[4*d +: 4] = add3(scratch[4*d +: 4]);
    end
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy and done are registered so downstream logic sees glitch-free flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != IDLE);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            bin_sr  <= bus.bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {scratch, bin_sr} <= {adj, bin_sr} << 1;
          cnt               <= cnt + CNT_W'(1);
        end
        DONE:    bcd_q <= scratch;
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner cases, an exhaustive sweep and
// random operands, all checked against a decimal-digit reference model.
module tb_bin2bcd_seq;
  localparam int BIN_W   = 8;
  localparam int DIGITS  = 3;
  localparam int LATENCY = BIN_W + 1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] refBcd(input int value);
    logic [4*DIGITS-1:0] res;
    int rem;
    res = '0;
    rem = value;
    for (int k = 0; k < DIGITS; k++) begin
      res[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next done pulse; cycles counts edges since the call.
  task automatic waitDone(input int limit, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (cycles < limit && !seen) begin
      tick();
      cycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  // One full conversion: pulse start, scramble bin after acceptance, check latency,
  // result and that done is a single-cycle pulse.
  task automatic applyStimulus(input int value, input string tag);
    int cycles;
    bit seen;
    bus.bin   = BIN_W'(value);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.bin   = BIN_W'($urandom);
    waitDone(LATENCY + 10, cycles, seen);
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(LATENCY));
    checkOutput({tag, "_bcd"}, 32'(bus.bcd), 32'(refBcd(value)));
    tick();
    checkOutput({tag, "_done_single"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int  cycles;
    bit  seen;
    int  done_count;
    int  gap;
    int  v;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_bcd", 32'(bus.bcd), 32'd0);
    rst = 1'b0;
    tick();

    applyStimulus(0, "zero");
    applyStimulus(255, "max");
    applyStimulus(99, "d99");
    applyStimulus(100, "d100");

    $display("[TB] exhaustive sweep");
    for (int i = 0; i < 256; i++) applyStimulus(i, "sweep");

    $display("[TB] random operands");
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      applyStimulus(int'($urandom_range(0, 255)), "rand");
    end

    // starts while busy are ignored and busy holds through DONE
    $display("[TB] start while busy");
    bus.bin   = 8'd37;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= LATENCY && !seen; c++) begin
      if (c == 2 || c == 4) begin
        bus.bin   = 8'd200;
        bus.start = 1'b1;
      end
      tick();
      bus.start = 1'b0;
      if (c < LATENCY) begin
        checkOutput("busy_hold", 32'(bus.busy), 32'd1);
        checkOutput("busy_no_done", 32'(bus.done), 32'd0);
      end else begin
        seen = 1'b1;
        checkOutput("busy_done", 32'(bus.done), 32'd1);
        checkOutput("busy_bcd", 32'(bus.bcd), 32'(refBcd(37)));
      end
    end
    tick();
    checkOutput("busy_not_queued", 32'(bus.busy), 32'd0);
    checkOutput("busy_done_single", 32'(bus.done), 32'd0);

    // reset mid-conversion aborts without a done pulse
    $display("[TB] reset abort");
    bus.bin   = 8'd180;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_bcd", 32'(bus.bcd), 32'd0);
    rst = 1'b0;
    done_count = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.done === 1'b1) done_count++;
    end
    checkOutput("abort_no_done", 32'(done_count), 32'd0);
    applyStimulus(7, "after_abort");

    // start held high gives back-to-back results
    $display("[TB] back-to-back");
    bus.bin   = 8'd42;
    bus.start = 1'b1;
    tick();
    bus.bin = 8'd128;
    waitDone(LATENCY + 10, cycles, seen);
    checkOutput("b2b_first_seen", 32'(seen), 32'd1);
    checkOutput("b2b_first_bcd", 32'(bus.bcd), 32'(refBcd(42)));
    tick();
    bus.start = 1'b0;
    waitDone(LATENCY + 10, cycles, seen);
    gap = cycles + 1;
    checkOutput("b2b_second_seen", 32'(seen), 32'd1);
    checkOutput("b2b_gap", 32'(gap), 32'(BIN_W + 2));
    checkOutput("b2b_second_bcd", 32'(bus.bcd), 32'(refBcd(128)));
    v = 0;
    repeat (LATENCY + 3) begin
      tick();
      if (bus.done === 1'b1) v++;
    end
    checkOutput("b2b_no_third", 32'(v), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
